// File: rtl/clock_pkg.sv
// Shared constants and types for the push-button input path.
// Button indices, channel FSM encoding and default timing.
package clock_pkg;

   localparam int unsigned N_BTN_DEF = 5;

   localparam int unsigned BTN_U = 0;
   localparam int unsigned BTN_D = 1;
   localparam int unsigned BTN_L = 2;
   localparam int unsigned BTN_R = 3;
   localparam int unsigned BTN_M = 4;

   // 5 ms, 500 ms and 100 ms at 100 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

   localparam logic [N_BTN_DEF-1:0] REPEAT_MASK_DEF =
      N_BTN_DEF'((1 << BTN_U) | (1 << BTN_D));

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HELD   = 2'd1,
      ST_REPEAT = 2'd2
   } btn_state_e;

   function automatic int unsigned cnt_width(
      input int unsigned max_val
   );
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One push button: 2-flop synchronizer, debouncer, press/release
// one-shots and the long-press / auto-repeat state machine.
module btn_channel
   import clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HW = cnt_width(REPEAT_DELAY);
   localparam int unsigned PW = cnt_width(REPEAT_PERIOD);

   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DELAY);
   localparam logic [PW-1:0] PER_LAST = PW'(REPEAT_PERIOD - 1);

   btn_state_e state_q, state_d;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          level_q, level_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [PW-1:0] per_q, per_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;

   logic differ;
   logic deb_hit;
   logic rise;
   logic fall;
   logic hold_hit;
   logic per_hit;

   always_comb begin
      sync1_d   = raw_i;
      sync2_d   = sync1_q;
      differ    = sync2_q ^ level_q;
      deb_hit   = differ && (deb_cnt_q == DEB_LAST);
      deb_cnt_d = (differ && !deb_hit) ? deb_cnt_q + 1'b1 : '0;
      level_d   = level_q ^ deb_hit;
      rise      = deb_hit && !level_q;
      fall      = deb_hit && level_q;
      hold_hit  = (state_q == ST_HELD) && (hold_q == HOLD_LAST);
      per_hit   = (state_q == ST_REPEAT) && (per_q == PER_LAST);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_HELD;
         end
         ST_HELD: begin
            if (fall)          state_d = ST_IDLE;
            else if (hold_hit) state_d = ST_REPEAT;
         end
         ST_REPEAT: begin
            if (fall) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A release edge always wins: counters clear and no repeat fires.
   always_comb begin
      hold_d = '0;
      per_d  = '0;
      if ((state_q != ST_IDLE) && !fall) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         if (state_q == ST_REPEAT) begin
            per_d = per_hit ? '0 : per_q + 1'b1;
         end
      end
      press_d   = rise ||
                  (REPEAT_EN && !fall && (hold_hit || per_hit));
      release_d = fall;
      long_d    = (long_q || hold_hit) && !fall;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_cnt_q <= '0;
         level_q   <= 1'b0;
         hold_q    <= '0;
         per_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_cnt_q <= deb_cnt_d;
         level_q   <= level_d;
         hold_q    <= hold_d;
         per_q     <= per_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/push_button_conditioner.sv
// Conditions the raw push buttons into clean clk-synchronous
// level, press, release and long-press signals.
module push_button_conditioner
   import clock_pkg::*;
#(
   parameter int unsigned       N_BTN           = N_BTN_DEF,
   parameter int unsigned       DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned       REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned       REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEF)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_BTN-1:0] push_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk       (clk),
         .resetn    (resetn),
         .raw_i     (push_raw[i]),
         .level_o   (btn_level[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i]),
         .long_o    (btn_long[i])
      );
   end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Scoreboard bench for push_button_conditioner using short
// sim timing and a cycle-level behavioural model of the buttons.
module tb_push_button_conditioner;

   localparam int DEB  = 4;
   localparam int DLY  = 20;
   localparam int PER  = 5;
   localparam int NB   = 5;
   localparam int MAXC = 10000;
   localparam logic [4:0] MASK = 5'b00011;

   typedef struct {
      int         cyc;
      logic [4:0] press;
      logic [4:0] rel;
      logic [4:0] lng;
      logic [4:0] lvl;
   } ev_t;

   logic       clk;
   logic       resetn;
   logic [4:0] push_raw;
   logic [4:0] btn_level;
   logic [4:0] btn_press;
   logic [4:0] btn_release;
   logic [4:0] btn_long;

   int total;
   int bad;
   int cyc;

   ev_t sbq[$];

   logic [4:0] raw_h [0:MAXC-1];
   bit         rn_h  [0:MAXC-1];

   logic [4:0] m_level;
   logic [4:0] m_held;
   logic [4:0] m_long;
   int         m_run   [0:NB-1];
   int         m_since [0:NB-1];
   logic [4:0] exp_long_prev;
   logic [4:0] dut_long_prev;

   push_button_conditioner #(
      .N_BTN           (NB),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (DLY),
      .REPEAT_PERIOD   (PER),
      .REPEAT_MASK     (MASK)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .push_raw    (push_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Predict outputs of cycle c from the raw/reset history.
   task automatic model_step(input int c);
      logic [4:0] s;
      logic [4:0] p;
      logic [4:0] rl;
      bit         tog;
      int         d;
      ev_t        e;
      s  = '0;
      p  = '0;
      rl = '0;
      if (c < 3 || !rn_h[c] || !rn_h[c-1]) begin
         m_level = '0;
         m_held  = '0;
         m_long  = '0;
         for (int b = 0; b < NB; b++) m_run[b] = 0;
      end else begin
         if (rn_h[c-3] && rn_h[c-2]) s = raw_h[c-3];
         for (int b = 0; b < NB; b++) begin
            tog = 1'b0;
            if (s[b] != m_level[b]) m_run[b] = m_run[b] + 1;
            else m_run[b] = 0;
            if (m_run[b] == DEB) begin
               m_run[b]   = 0;
               m_level[b] = ~m_level[b];
               tog        = 1'b1;
            end
            if (tog && m_level[b]) begin
               p[b]       = 1'b1;
               m_held[b]  = 1'b1;
               m_since[b] = c;
            end else if (tog) begin
               rl[b]     = 1'b1;
               m_held[b] = 1'b0;
               m_long[b] = 1'b0;
            end else if (m_held[b]) begin
               d = c - m_since[b];
               if (d >= DLY) m_long[b] = 1'b1;
               if (MASK[b] && d >= DLY && ((d - DLY) % PER) == 0)
                  p[b] = 1'b1;
            end
         end
      end
      if (p != 0 || rl != 0 || m_long != exp_long_prev) begin
         e.cyc   = c;
         e.press = p;
         e.rel   = rl;
         e.lng   = m_long;
         e.lvl   = m_level;
         sbq.push_back(e);
      end
      exp_long_prev = m_long;
   endtask

   task automatic tick(input logic [4:0] r, input logic rn);
      @(posedge clk);
      #1;
      push_raw = r;
      resetn   = rn;
      raw_h[cyc] = r;
      rn_h[cyc]  = rn;
      model_step(cyc);
   endtask

   task automatic hold(input logic [4:0] r, input int n);
      for (int k = 0; k < n; k++) tick(r, 1'b1);
   endtask

   // Monitor: any pulse or change of btn_long is an output event.
   always @(negedge clk) begin
      ev_t e;
      bit  evt;
      evt = (btn_press != 0) || (btn_release != 0) ||
            (btn_long != dut_long_prev);
      dut_long_prev = btn_long;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         e = sbq.pop_front();
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL missed_event cyc=%0d got none, want press=%b rel=%b long=%b",
                  e.cyc, e.press, e.rel, e.lng);
      end
      if (evt) begin
         total = total + 1;
         if (sbq.size() == 0) begin
            bad = bad + 1;
            $display("FAIL spurious_event cyc=%0d got press=%b rel=%b long=%b, want none",
                     cyc, btn_press, btn_release, btn_long);
         end else begin
            e = sbq.pop_front();
            if (e.cyc != cyc || e.press != btn_press ||
                e.rel != btn_release || e.lng != btn_long ||
                e.lvl != btn_level) begin
               bad = bad + 1;
               $display("FAIL event got cyc=%0d press=%b rel=%b long=%b lvl=%b, want cyc=%0d press=%b rel=%b long=%b lvl=%b",
                        cyc, btn_press, btn_release, btn_long, btn_level,
                        e.cyc, e.press, e.rel, e.lng, e.lvl);
            end
         end
      end
   end

   initial begin
      logic [4:0] r;
      int         rate;
      total         = 0;
      bad           = 0;
      push_raw      = '0;
      resetn        = 1'b0;
      m_level       = '0;
      m_held        = '0;
      m_long        = '0;
      exp_long_prev = '0;
      dut_long_prev = '0;
      for (int b = 0; b < NB; b++) begin
         m_run[b]   = 0;
         m_since[b] = 0;
      end

      // all buttons down through reset, then released
      repeat (3) tick(5'b11111, 1'b0);
      hold(5'b11111, 30);
      hold(5'b00000, 12);

      // bouncing up button, then held into repeat
      for (int k = 0; k < 5; k++) begin
         r = (k % 2 == 0) ? 5'b00001 : 5'b00000;
         hold(r, 2);
      end
      hold(5'b00001, 45);
      hold(5'b00000, 12);

      // middle held past the long threshold
      hold(5'b10000, 40);
      hold(5'b00000, 12);

      // left and right together, released apart
      hold(5'b01100, 10);
      hold(5'b01000, 8);
      hold(5'b00000, 12);

      // reset while up is auto-repeating
      hold(5'b00001, 35);
      repeat (3) tick(5'b00001, 1'b0);
      hold(5'b00001, 40);
      hold(5'b00000, 12);

      // random traffic with varying bounce rates and rare resets
      r = '0;
      for (int blk = 0; blk < 6; blk++) begin
         rate = (blk % 2 == 0) ? 12 : 40;
         for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < NB; b++)
               if ($urandom_range(rate - 1, 0) == 0) r[b] = ~r[b];
            if ($urandom_range(599, 0) == 0) begin
               repeat ($urandom_range(3, 1)) tick(r, 1'b0);
            end
            tick(r, 1'b1);
         end
      end
      hold(5'b00000, 12);

      @(negedge clk);
      @(negedge clk);
      #1;
      total = total + 1;
      if (sbq.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain got %0d pending events, want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
